// File: rtl/pcc_pkg.sv
// pcc_pkg: shared constants, FSM state type, per-feature thresholds and the
// binarization helper for the popcount-compare (pcc) producer and evaluator.
package pcc_pkg;

    localparam int unsigned N_POS_DEF  = 6;
    localparam int unsigned N_NEG_DEF  = 9;
    localparam int unsigned FEAT_W_DEF = 8;
    localparam int unsigned F_DEF      = N_POS_DEF + N_NEG_DEF;
    localparam int unsigned IDX_W_DEF  = $clog2(F_DEF);

    typedef enum logic {ST_COLLECT, ST_PRESENT} state_e;

    // Per-feature thresholds, indexed by position in the frame.
    // Entry 5 is all-ones, so only an all-ones sample binarizes to 1 there.
    localparam logic [FEAT_W_DEF-1:0] THRESH [F_DEF] = '{
        8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'hFF,
        8'h7F, 8'h33, 8'hC0, 8'h05, 8'hAA, 8'h55, 8'hFE, 8'h90, 8'h02
    };

    // Unsigned compare against the threshold of feature idx; out-of-range idx gives 0.
    function automatic logic feat_bit(input logic [FEAT_W_DEF-1:0] value,
                                      input logic [IDX_W_DEF-1:0]  idx);
        if (32'(idx) >= F_DEF) return 1'b0;
        return value >= THRESH[idx];
    endfunction

endpackage

// File: rtl/pcc_vector_assembler_if.sv
// pcc_vector_assembler_if: sample stream in, vector pair out.
//   in_valid/in_ready/in_feat/in_last : serial feature samples from upstream
//   out_valid/out_ready/pos_o/neg_o   : completed vector pair to the evaluator
//   err_o                             : framing error pulse
// master = upstream/evaluator side, slave = assembler side.
interface pcc_vector_assembler_if
    import pcc_pkg::*;
#(
    parameter int unsigned N_POS  = N_POS_DEF,
    parameter int unsigned N_NEG  = N_NEG_DEF,
    parameter int unsigned FEAT_W = FEAT_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [FEAT_W-1:0] in_feat;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [N_POS-1:0]  pos_o;
    logic [N_NEG-1:0]  neg_o;
    logic              err_o;

    modport master (
        output in_valid, in_feat, in_last, out_ready,
        input  in_ready, out_valid, pos_o, neg_o, err_o
    );

    modport slave (
        input  in_valid, in_feat, in_last, out_ready,
        output in_ready, out_valid, pos_o, neg_o, err_o
    );
endinterface

// File: rtl/pcc_feat_binarizer.sv
// pcc_feat_binarizer: combinational thresholding of one raw feature sample.
//   feat_i : raw unsigned sample
//   idx_i  : feature position within the frame
//   bit_o  : 1 when feat_i >= THRESH[idx_i]
module pcc_feat_binarizer
    import pcc_pkg::*;
(
    input  logic [FEAT_W_DEF-1:0] feat_i,
    input  logic [IDX_W_DEF-1:0]  idx_i,
    output logic                  bit_o
);
    assign bit_o = feat_bit(feat_i, idx_i);
endmodule

// File: rtl/pcc_vector_assembler.sv
// pcc_vector_assembler: collects F = N_POS+N_NEG serial samples, binarizes each
// against its threshold and presents the packed pos/neg vectors over valid/ready.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : pcc_vector_assembler_if.slave (sample input, vector output, err_o)
// Optional: define PCC_FRAME_CHECK_EN to check in_last against the sample count;
// otherwise in_last is ignored and err_o is tied 0.
module pcc_vector_assembler
    import pcc_pkg::*;
#(
    parameter int unsigned N_POS  = N_POS_DEF,
    parameter int unsigned N_NEG  = N_NEG_DEF,
    parameter int unsigned FEAT_W = FEAT_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    pcc_vector_assembler_if.slave bus
);
    localparam int unsigned F     = N_POS + N_NEG;
    localparam int unsigned IDX_W = $clog2(F);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_POS-1:0] pos_q, pos_d;
    logic [N_NEG-1:0] neg_q, neg_d;
    logic             err_q, err_d;
    logic             feat_bit_w;
    logic             last_sample;

    pcc_feat_binarizer u_binarizer (
        .feat_i (bus.in_feat),
        .idx_i  (idx_q),
        .bit_o  (feat_bit_w)
    );

    assign last_sample = (idx_q == IDX_W'(F - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        err_d   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < N_POS; i++) begin
                        if (idx_q == IDX_W'(i)) pos_d[i] = feat_bit_w;
                    end
                    for (int j = 0; j < N_NEG; j++) begin
                        if (idx_q == IDX_W'(N_POS + j)) neg_d[j] = feat_bit_w;
                    end
                    if (last_sample) begin
                        state_d = ST_PRESENT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
`ifdef PCC_FRAME_CHECK_EN
                    // Early in_last aborts the frame; a missing in_last is flagged
                    // but the frame still goes out because the count is authoritative.
                    if (bus.in_last && !last_sample) begin
                        err_d = 1'b1;
                        pos_d = '0;
                        neg_d = '0;
                        idx_d = '0;
                    end else if (!bus.in_last && last_sample) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            ST_PRESENT: begin
                // Vectors hold while stalled; cleared on the handshake.
                if (bus.out_ready) begin
                    state_d = ST_COLLECT;
                    pos_d   = '0;
                    neg_d   = '0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_COLLECT);
    assign bus.out_valid = (state_q == ST_PRESENT);
    assign bus.pos_o     = pos_q;
    assign bus.neg_o     = neg_q;

`ifdef PCC_FRAME_CHECK_EN
    assign bus.err_o = err_q;
`else
    logic unused_frame_check;
    assign unused_frame_check = bus.in_last ^ err_q;
    assign bus.err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_pcc_vector_assembler.sv
// Bench for pcc_vector_assembler: table-driven frames, hand-written stall/reset/
// framing sequences and randomized traffic, all checked every cycle against a
// frame-level reference model kept here.
module tb_pcc_vector_assembler;
    localparam int F = 15;

    typedef struct {
        string      name;
        int         mode;  // 0: fill (+ optional single override), 1: thresh-1, 2: thresh
        logic [7:0] fill;
        int         sidx;
        logic [7:0] sval;
        logic [5:0] exp_pos;
        logic [8:0] exp_neg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcc_vector_assembler_if bus ();

    pcc_vector_assembler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] th [F] = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'hFF, 8'h7F, 8'h33,
                           8'hC0, 8'h05, 8'hAA, 8'h55, 8'hFE, 8'h90, 8'h02};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: samples of the frame in progress, presenting flag, error pulse.
    logic [7:0] m_q [$];
    bit         m_pres = 0;
    bit         m_err  = 0;

    vec_t tab [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [14:0] exp_bits();
        logic [14:0] b;
        b = '0;
        for (int i = 0; i < m_q.size(); i++) b[i] = (m_q[i] >= th[i]);
        return b;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input logic r, input logic v, input logic [7:0] f,
                              input logic l, input logic o);
        int pos;
        m_err = 0;
        if (r) begin
            m_q.delete();
            m_pres = 0;
        end else if (!m_pres) begin
            if (v) begin
                pos = m_q.size();
                m_q.push_back(f);
`ifdef PCC_FRAME_CHECK_EN
                if (l && pos < F - 1) begin
                    m_err = 1;
                    m_q.delete();
                end else if (!l && pos == F - 1) begin
                    m_err = 1;
                end
`else
                if (l && pos < 0) m_err = 1;
`endif
                if (m_q.size() == F) m_pres = 1;
            end
        end else if (o) begin
            m_pres = 0;
            m_q.delete();
        end
    endtask

    task automatic check_model();
        logic [14:0] b;
        b = exp_bits();
        chk("in_ready",  bus.in_ready,  !m_pres);
        chk("out_valid", bus.out_valid, m_pres);
        chk("pos_o",     bus.pos_o,     b[5:0]);
        chk("neg_o",     bus.neg_o,     b[14:6]);
        chk("err_o",     bus.err_o,     m_err);
    endtask

    task automatic drive_cycle(input logic r, input logic v, input logic [7:0] f,
                               input logic l, input logic o);
        rst           = r;
        bus.in_valid  = v;
        bus.in_feat   = f;
        bus.in_last   = l;
        bus.out_ready = o;
        model_edge(r, v, f, l, o);
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    function automatic logic [7:0] rec_feat(input vec_t r, input int i);
        if (r.mode == 1) return th[i] - 8'd1;
        if (r.mode == 2) return th[i];
        if (i == r.sidx) return r.sval;
        return r.fill;
    endfunction

    task automatic send_rec(input vec_t r);
        for (int i = 0; i < F; i++) drive_cycle(1'b0, 1'b1, rec_feat(r, i), i == F - 1, 1'b1);
        chk({r.name, " out_valid"}, bus.out_valid, 1'b1);
        chk({r.name, " pos"}, bus.pos_o, r.exp_pos);
        chk({r.name, " neg"}, bus.neg_o, r.exp_neg);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk({r.name, " single-cycle valid"}, bus.out_valid, 1'b0);
    endtask

    task automatic run_random(input int n);
        logic r, v, l, o;
        for (int c = 0; c < n; c++) begin
            r = ($urandom_range(99) == 0);
            v = ($urandom_range(9) < 7);
            o = 1'($urandom_range(1));
            l = (m_q.size() == F - 1);
            if ($urandom_range(19) == 0) l = !l;
            drive_cycle(r, v, 8'($urandom), l, o);
        end
    endtask

    initial begin
        int         vcyc [$];
        logic [7:0] cur;

        tab[0] = '{"all_ff",    0, 8'hFF, -1, 8'h00, 6'h3F, 9'h1FF};
        tab[1] = '{"all_zero",  0, 8'h00, -1, 8'h00, 6'h00, 9'h000};
        tab[2] = '{"thr3_only", 0, 8'h00,  3, 8'h80, 6'h08, 9'h000};
        tab[3] = '{"thresh_m1", 1, 8'h00, -1, 8'h00, 6'h00, 9'h000};
        tab[4] = '{"at_thresh", 2, 8'h00, -1, 8'h00, 6'h3F, 9'h1FF};
        tab[5] = '{"all_fe",    0, 8'hFE, -1, 8'h00, 6'h1F, 9'h1FF};
        tab[6] = '{"all_80",    0, 8'h80, -1, 8'h00, 6'h1F, 9'h12B};

        // Reset state
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        chk("reset in_ready", bus.in_ready, 1'b1);
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset pos", bus.pos_o, 6'h00);
        chk("reset neg", bus.neg_o, 9'h000);

        foreach (tab[k]) send_rec(tab[k]);

        // Evaluator stall for 20 cycles with upstream holding a sample
        for (int i = 0; i < F; i++) drive_cycle(1'b0, 1'b1, 8'hFF, i == F - 1, 1'b0);
        for (int s = 0; s < 20; s++) begin
            drive_cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
            chk("stall out_valid", bus.out_valid, 1'b1);
            chk("stall in_ready", bus.in_ready, 1'b0);
            chk("stall pos", bus.pos_o, 6'h3F);
            chk("stall neg", bus.neg_o, 9'h1FF);
        end
        drive_cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        chk("handshake in_ready", bus.in_ready, 1'b1);
        chk("handshake cleared pos", bus.pos_o, 6'h00);
        drive_cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        chk("first sample after handshake", bus.pos_o, 6'h01);
        for (int i = 1; i < F; i++) drive_cycle(1'b0, 1'b1, 8'hFF, i == F - 1, 1'b1);
        chk("post-stall frame valid", bus.out_valid, 1'b1);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset during sample 9, then a fresh frame
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        chk("mid-frame reset pos", bus.pos_o, 6'h00);
        send_rec(tab[6]);

        // Back-to-back frames, upstream holds each sample until accepted
        cur = 8'($urandom);
        for (int c = 0; c < 3 * (F + 1); c++) begin
            logic acc;
            acc = !m_pres;
            drive_cycle(1'b0, 1'b1, cur, m_q.size() == F - 1, 1'b1);
            if (bus.out_valid) vcyc.push_back(cyc);
            if (acc) cur = 8'($urandom);
        end
        chk("b2b frame count", vcyc.size(), 3);
        for (int k = 1; k < vcyc.size(); k++) chk("b2b period", vcyc[k] - vcyc[k-1], F + 1);

        // Early in_last on sample 7
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, 8'hFF, i == 7, 1'b1);
`ifdef PCC_FRAME_CHECK_EN
        chk("early last err", bus.err_o, 1'b1);
        chk("early last no valid", bus.out_valid, 1'b0);
        send_rec(tab[0]);
`else
        chk("early last err", bus.err_o, 1'b0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        chk("last ignored valid", bus.out_valid, 1'b1);
        chk("last ignored pos", bus.pos_o, 6'h3F);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        send_rec(tab[0]);
`endif

        run_random(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
